// File: rtl/descracker_axil_regbank.sv
// rtl/descracker_axil_regbank.sv - AXI4-Lite register bank for the DES cracker cores
//
// Register 0 is CTRL (START self-clearing, IRQ_EN), register 1 is STATUS
// (BUSY live, DONE/FOUND sticky W1C). Registers 2..NUM_REGS-1 are either
// byte-strobed configuration or read-only windows onto ro_regs (RO_MASK).
//
// Ports:
//   s00_axi_aclk, s00_axi_reset   clock, synchronous active-high reset
//   s00_axi_aw*/w*/b*             AXI4-Lite write address/data/response
//   s00_axi_ar*/r*                AXI4-Lite read address/data
//   cfg_regs                      flat image of all registers, reg i at [32i+31:32i]
//   ro_regs                       live values for read-only registers
//   core_busy/done/found          cracker status inputs (done/found are pulses)
//   start_pulse                   one-cycle start request
//   irq                           level interrupt, IRQ_EN & (DONE | FOUND)
module descracker_axil_regbank #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int NUM_REGS = 8,
   parameter int C_S_AXI_ADDR_WIDTH = 5,
   parameter logic [NUM_REGS-1:0] RO_MASK = 'hC0
) (
   input  logic                            s00_axi_aclk,
   input  logic                            s00_axi_reset,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
   input  logic [2:0]                      s00_axi_awprot,
   input  logic                            s00_axi_awvalid,
   output logic                            s00_axi_awready,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
   input  logic                            s00_axi_wvalid,
   output logic                            s00_axi_wready,
   output logic [1:0]                      s00_axi_bresp,
   output logic                            s00_axi_bvalid,
   input  logic                            s00_axi_bready,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
   input  logic [2:0]                      s00_axi_arprot,
   input  logic                            s00_axi_arvalid,
   output logic                            s00_axi_arready,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
   output logic [1:0]                      s00_axi_rresp,
   output logic                            s00_axi_rvalid,
   input  logic                            s00_axi_rready,
   output logic [NUM_REGS*32-1:0]          cfg_regs,
   input  logic [NUM_REGS*32-1:0]          ro_regs,
   input  logic                            core_busy,
   input  logic                            core_done,
   input  logic                            core_found,
   output logic                            start_pulse,
   output logic                            irq
);

   localparam int IW = C_S_AXI_ADDR_WIDTH - 2;

   // Held low through the first cycle after reset so no handshake is offered
   // until the bank has seen one clean cycle.
   logic          ready_en;

   logic          aw_full;
   logic [IW-1:0] aw_idx;
   logic          w_full;
   logic [31:0]   w_data;
   logic [3:0]    w_strb;
   logic          bvalid_q;
   logic [1:0]    bresp_q;

   logic          rvalid_q;
   logic [31:0]   rdata_q;
   logic [31:0]   rd_mux;
   logic [IW-1:0] ar_idx;

   logic          irq_en;
   logic          st_done;
   logic          st_found;
   logic          busy_q;
   logic          start_q;
   logic          irq_q;
   logic [31:0]   gen_regs [NUM_REGS];

   logic          aw_hs;
   logic          w_hs;
   logic          ar_hs;
   logic          commit;
   logic          wr_ctrl;
   logic          wr_status;
   logic          wr_ro;
   logic          clr_done;
   logic          clr_found;

   assign s00_axi_awready = ready_en & ~aw_full & ~bvalid_q;
   assign s00_axi_wready  = ready_en & ~w_full & ~bvalid_q;
   assign s00_axi_arready = ready_en & ~rvalid_q;
   assign s00_axi_bvalid  = bvalid_q;
   assign s00_axi_bresp   = bresp_q;
   assign s00_axi_rvalid  = rvalid_q;
   assign s00_axi_rdata   = rdata_q;
   assign s00_axi_rresp   = 2'b00;
   assign start_pulse     = start_q;
   assign irq             = irq_q;

   assign aw_hs  = s00_axi_awvalid & s00_axi_awready;
   assign w_hs   = s00_axi_wvalid & s00_axi_wready;
   assign ar_hs  = s00_axi_arvalid & s00_axi_arready;
   assign ar_idx = s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];

   // Commit happens in the cycle where both halves sit in their latches.
   assign commit    = aw_full & w_full;
   assign wr_ctrl   = commit && (aw_idx == IW'(0));
   assign wr_status = commit && (aw_idx == IW'(1));
   assign wr_ro     = (aw_idx >= IW'(2)) && RO_MASK[aw_idx];
   assign clr_done  = wr_status & w_strb[0] & w_data[1];
   assign clr_found = wr_status & w_strb[0] & w_data[2];

   logic unused_bits;
   assign unused_bits = ^{s00_axi_awprot, s00_axi_arprot,
                          s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

   always_comb begin
      rd_mux = '0;
      if (ar_idx == IW'(0))
         rd_mux = {30'd0, irq_en, 1'b0};
      else if (ar_idx == IW'(1))
         rd_mux = {29'd0, st_found, st_done, core_busy};
      else if (RO_MASK[ar_idx])
         rd_mux = ro_regs[32*ar_idx +: 32];
      else
         rd_mux = gen_regs[ar_idx];
   end

   always_ff @(posedge s00_axi_aclk) begin
      if (s00_axi_reset) begin
         ready_en <= 1'b0;
         aw_full  <= 1'b0;
         aw_idx   <= '0;
         w_full   <= 1'b0;
         w_data   <= '0;
         w_strb   <= '0;
         bvalid_q <= 1'b0;
         bresp_q  <= 2'b00;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         irq_en   <= 1'b0;
         st_done  <= 1'b0;
         st_found <= 1'b0;
         busy_q   <= 1'b0;
         start_q  <= 1'b0;
         irq_q    <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++)
            gen_regs[i] <= '0;
      end else begin
         ready_en <= 1'b1;
         busy_q   <= core_busy;
         start_q  <= 1'b0;

         if (aw_hs) begin
            aw_full <= 1'b1;
            aw_idx  <= s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
         end
         if (w_hs) begin
            w_full <= 1'b1;
            w_data <= s00_axi_wdata;
            w_strb <= s00_axi_wstrb;
         end

         if (commit) begin
            aw_full  <= 1'b0;
            w_full   <= 1'b0;
            bvalid_q <= 1'b1;
            bresp_q  <= wr_ro ? 2'b10 : 2'b00;
         end else if (bvalid_q && s00_axi_bready) begin
            bvalid_q <= 1'b0;
         end

         if (wr_ctrl && w_strb[0]) begin
            irq_en  <= w_data[1];
            start_q <= w_data[0] & ~core_busy;
         end

         // Hardware set dominates a simultaneous W1C.
         st_done  <= core_done | (st_done & ~clr_done);
         st_found <= core_found | (st_found & ~clr_found);
         irq_q    <= irq_en & (st_done | st_found);

         for (int i = 2; i < NUM_REGS; i++) begin
            if (commit && (aw_idx == IW'(i)) && !RO_MASK[i]) begin
               for (int b = 0; b < 4; b++) begin
                  if (w_strb[b])
                     gen_regs[i][8*b +: 8] <= w_data[8*b +: 8];
               end
            end
         end

         if (ar_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_mux;
         end else if (rvalid_q && s00_axi_rready) begin
            rvalid_q <= 1'b0;
         end
      end
   end

   // Read-only slots carry no storage, so their image stays zero.
   for (genvar g = 0; g < NUM_REGS; g++) begin : g_cfg
      if (g == 0) begin : g_ctrl
         assign cfg_regs[31:0] = {30'd0, irq_en, 1'b0};
      end else if (g == 1) begin : g_status
         assign cfg_regs[63:32] = {29'd0, st_found, st_done, busy_q};
      end else begin : g_gen
         assign cfg_regs[32*g +: 32] = gen_regs[g];
      end
   end

endmodule

// File: tb/tb_descracker_axil_regbank.sv
// tb/tb_descracker_axil_regbank.sv - self-checking bench for descracker_axil_regbank
module tb_descracker_axil_regbank;
   localparam int NR = 8;
   localparam int AW = 5;
   localparam logic [NR-1:0] ROM = 8'hC0;

   logic clk = 1'b0;
   logic rst;
   logic [AW-1:0] awaddr;
   logic [2:0] awprot;
   logic awvalid, awready;
   logic [31:0] wdata;
   logic [3:0] wstrb;
   logic wvalid, wready;
   logic [1:0] bresp;
   logic bvalid, bready;
   logic [AW-1:0] araddr;
   logic [2:0] arprot;
   logic arvalid, arready;
   logic [31:0] rdata;
   logic [1:0] rresp;
   logic rvalid, rready;
   logic [NR*32-1:0] cfg_regs;
   logic [NR*32-1:0] ro_regs;
   logic core_busy, core_done, core_found, start_pulse, irq;

   int total = 0;
   int bad = 0;
   int start_cnt = 0;

   logic [31:0] m_rw [NR];
   bit m_irq_en, m_done, m_found;

   always #5 clk = ~clk;

   always @(negedge clk) if (start_pulse === 1'b1) start_cnt++;

   descracker_axil_regbank #(
      .C_S_AXI_DATA_WIDTH(32), .NUM_REGS(NR), .C_S_AXI_ADDR_WIDTH(AW), .RO_MASK(ROM)
   ) dut (
      .s00_axi_aclk(clk), .s00_axi_reset(rst),
      .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot),
      .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
      .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb),
      .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
      .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
      .s00_axi_araddr(araddr), .s00_axi_arprot(arprot),
      .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
      .s00_axi_rdata(rdata), .s00_axi_rresp(rresp),
      .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
      .cfg_regs(cfg_regs), .ro_regs(ro_regs),
      .core_busy(core_busy), .core_done(core_done), .core_found(core_found),
      .start_pulse(start_pulse), .irq(irq)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference model: register semantics as a programmer sees them.
   function automatic logic [31:0] model_read(input int idx);
      if (idx == 0) return {30'd0, m_irq_en, 1'b0};
      if (idx == 1) return {29'd0, m_found, m_done, core_busy};
      if (ROM[idx]) return ro_regs[idx*32 +: 32];
      return m_rw[idx];
   endfunction

   function automatic logic [1:0] model_write(input int idx, input logic [31:0] d,
                                              input logic [3:0] s, output bit pulse);
      pulse = 1'b0;
      if (idx == 0) begin
         if (s[0]) begin
            m_irq_en = d[1];
            pulse = d[0] && !core_busy;
         end
         return 2'b00;
      end
      if (idx == 1) begin
         if (s[0] && d[1]) m_done = 1'b0;
         if (s[0] && d[2]) m_found = 1'b0;
         return 2'b00;
      end
      if (ROM[idx]) return 2'b10;
      for (int b = 0; b < 4; b++)
         if (s[b]) m_rw[idx][8*b +: 8] = d[8*b +: 8];
      return 2'b00;
   endfunction

   task automatic do_write(input int idx, input logic [31:0] d, input logic [3:0] s,
                           input bit pulse_found, output logic [1:0] resp);
      bit awd = 1'b0;
      bit wd = 1'b0;
      bit got = 1'b0;
      awaddr = AW'(idx*4 + int'($urandom_range(0, 3)));
      wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
      for (int n = 0; n < 40 && !(awd && wd); n++) begin
         @(negedge clk);
         if (awvalid && awready) awd = 1'b1;
         if (wvalid && wready) wd = 1'b1;
         @(posedge clk); #1;
         if (awd) awvalid = 1'b0;
         if (wd) wvalid = 1'b0;
      end
      awvalid = 1'b0; wvalid = 1'b0;
      check("w_accept", 64'({awd, wd}), 64'(2'b11));
      if (pulse_found) core_found = 1'b1;
      resp = 2'bxx;
      for (int n = 0; n < 40 && !got; n++) begin
         @(negedge clk);
         got = bvalid;
         resp = bresp;
         @(posedge clk); #1;
         core_found = 1'b0;
      end
      check("b_wait", 64'(got), 64'(1));
   endtask

   task automatic do_read(input int idx, output logic [31:0] d);
      bit got = 1'b0;
      araddr = AW'(idx*4 + int'($urandom_range(0, 3)));
      arvalid = 1'b1; rready = 1'b1;
      for (int n = 0; n < 40 && !got; n++) begin
         @(negedge clk);
         got = arready;
         @(posedge clk); #1;
      end
      arvalid = 1'b0;
      check("ar_wait", 64'(got), 64'(1));
      got = 1'b0;
      d = 'x;
      for (int n = 0; n < 40 && !got; n++) begin
         @(negedge clk);
         got = rvalid;
         d = rdata;
         if (got) check("rresp", 64'(rresp), 64'(0));
         @(posedge clk); #1;
      end
      check("r_wait", 64'(got), 64'(1));
   endtask

   task automatic rd_chk(input string tag, input int idx);
      logic [31:0] exp, d;
      exp = model_read(idx);
      do_read(idx, d);
      check(tag, 64'(d), 64'(exp));
   endtask

   task automatic wr(input int idx, input logic [31:0] d, input logic [3:0] s, input bit pf);
      logic [1:0] exp_resp, resp;
      bit pulse;
      int sc;
      sc = start_cnt;
      exp_resp = model_write(idx, d, s, pulse);
      if (pf) m_found = 1'b1;
      do_write(idx, d, s, pf, resp);
      check("bresp", 64'(resp), 64'(exp_resp));
      repeat (2) @(posedge clk);
      #1;
      check("start_cnt", 64'(start_cnt - sc), 64'(pulse));
      check("irq", 64'(irq), 64'(m_irq_en & (m_done | m_found)));
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d, sv_r;
      logic [2:0] sv_b;
      bit got, got2;
      int bcnt, sel, ridx;
      logic [31:0] rdat;
      logic [3:0] rstb;

      rst = 1'b1;
      awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
      bready = 1'b0; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
      ro_regs = '0; core_busy = 1'b0; core_done = 1'b0; core_found = 1'b0;
      for (int i = 0; i < NR; i++) m_rw[i] = '0;
      m_irq_en = 1'b0; m_done = 1'b0; m_found = 1'b0;

      // Reset
      repeat (5) begin
         @(negedge clk);
         check("rst_ready", 64'({awready, wready, arready, bvalid, rvalid}), 64'(0));
         check("rst_out", 64'({irq, start_pulse, bresp, rresp, (rdata != 0), (cfg_regs != '0)}), 64'(0));
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("post_rst", 64'({awready, wready, arready, irq, start_pulse, bvalid, rvalid, (cfg_regs != '0)}), 64'(0));
      @(posedge clk); #1;
      for (int i = 0; i < NR; i++) rd_chk("rst_read", i);

      // Strobed write
      wr(2, 32'h11223344, 4'hF, 1'b0);
      wr(2, 32'hAABBCCDD, 4'b0101, 1'b0);
      rd_chk("strobe_read", 2);
      check("strobe_cfg", 64'(cfg_regs[95:64]), 64'(m_rw[2]));

      // W three cycles ahead of AW
      wdata = 32'h5A5A0F0F; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1;
      got = 1'b0;
      for (int n = 0; n < 40 && !got; n++) begin
         @(negedge clk); got = wready; @(posedge clk); #1;
      end
      wvalid = 1'b0;
      check("ord_w", 64'(got), 64'(1));
      repeat (3) begin
         @(negedge clk); check("ord_nob", 64'(bvalid), 64'(0)); @(posedge clk); #1;
      end
      awaddr = AW'(4*4); awvalid = 1'b1;
      got = 1'b0; bcnt = 0;
      for (int n = 0; n < 40 && !got; n++) begin
         @(negedge clk); got = awready; bcnt += int'(bvalid); @(posedge clk); #1;
      end
      awvalid = 1'b0;
      check("ord_aw", 64'(got), 64'(1));
      repeat (6) begin
         @(negedge clk); bcnt += int'(bvalid); @(posedge clk); #1;
      end
      check("ord_bcnt", 64'(bcnt), 64'(1));
      m_rw[4] = 32'h5A5A0F0F;
      rd_chk("ord_read", 4);

      // Read-only register
      ro_regs[255:224] = 32'hDEADBEEF;
      wr(7, 32'h12345678, 4'hF, 1'b0);
      rd_chk("ro_read", 7);

      // Start pulse
      core_busy = 1'b0;
      wr(0, 32'h1, 4'hF, 1'b0);
      core_busy = 1'b1;
      wr(0, 32'h1, 4'hF, 1'b0);
      core_busy = 1'b0;

      // Status and irq
      wr(0, 32'h2, 4'hF, 1'b0);
      core_found = 1'b1; @(posedge clk); #1; core_found = 1'b0;
      m_found = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rd_chk("found_status", 1);
      check("found_irq", 64'(irq), 64'(1));
      wr(1, 32'h4, 4'h1, 1'b1);
      rd_chk("set_wins", 1);
      wr(1, 32'h4, 4'h1, 1'b0);
      rd_chk("w1c_status", 1);
      check("w1c_irq", 64'(irq), 64'(0));

      // Backpressure with overlapping write and read
      awaddr = AW'(3*4); wdata = 32'hCAFEF00D; wstrb = 4'hF;
      araddr = AW'(3*4);
      awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b0; rready = 1'b0;
      @(negedge clk);
      check("bp_accept", 64'({awready, wready, arready}), 64'(3'b111));
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      sv_r = m_rw[3];
      m_rw[3] = 32'hCAFEF00D;
      got = 1'b0; got2 = 1'b0;
      for (int n = 0; n < 20 && !(got && got2); n++) begin
         @(negedge clk); got = bvalid; got2 = rvalid; @(posedge clk); #1;
      end
      check("bp_valid", 64'({got, got2}), 64'(2'b11));
      sv_b = {1'b1, 2'b00};
      repeat (10) begin
         @(negedge clk);
         check("bp_b", 64'({bvalid, bresp}), 64'(sv_b));
         check("bp_r", 64'({rvalid, rdata}), 64'({1'b1, sv_r}));
         check("bp_ready", 64'({awready, wready, arready}), 64'(0));
         @(posedge clk); #1;
      end
      bready = 1'b1; rready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check("bp_release", 64'({bvalid, rvalid, awready, wready, arready}), 64'(5'b00111));
      @(posedge clk); #1;
      rd_chk("bp_read", 3);

      // Randomised traffic against the model
      for (int it = 0; it < 80; it++) begin
         core_busy = 1'($urandom_range(0, 1));
         ro_regs[6*32 +: 32] = $urandom;
         ro_regs[7*32 +: 32] = $urandom;
         sel = int'($urandom_range(0, 5));
         ridx = int'($urandom_range(0, NR-1));
         if (sel == 0) begin
            core_done = 1'b1; @(posedge clk); #1; core_done = 1'b0;
            m_done = 1'b1;
            repeat (2) @(posedge clk);
            #1;
            check("rnd_irq", 64'(irq), 64'(m_irq_en & (m_done | m_found)));
         end else if (sel == 1) begin
            core_found = 1'b1; @(posedge clk); #1; core_found = 1'b0;
            m_found = 1'b1;
            repeat (2) @(posedge clk);
            #1;
            check("rnd_irq", 64'(irq), 64'(m_irq_en & (m_done | m_found)));
         end else if (sel <= 3) begin
            rdat = $urandom;
            rstb = 4'($urandom_range(0, 15));
            wr(ridx, rdat, rstb, 1'b0);
         end else begin
            rd_chk("rnd_read", ridx);
         end
      end
      for (int i = 2; i < NR; i++)
         if (!ROM[i]) check("rnd_cfg", 64'(cfg_regs[32*i +: 32]), 64'(m_rw[i]));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
